// File: rtl/arcabuco_memory_stage.sv
// arcabuco_memory_stage: MEM stage that runs data bus transactions, aligns loads and forwards results.
// Define MEMSTAGE_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of issuing them.
module arcabuco_memory_stage #(
  parameter int XLEN = 32,
  parameter int REGADDR_W = 5
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 ex_valid,
  output logic                 ex_ready,
  input  logic [XLEN-1:0]      ex_result,
  input  logic [XLEN-1:0]      ex_store_data,
  input  logic [3:0]           ex_mem_op,
  input  logic [REGADDR_W-1:0] ex_rd,
  input  logic                 ex_rd_we,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [XLEN-1:0]      dmem_addr,
  output logic [3:0]           dmem_be,
  output logic [XLEN-1:0]      dmem_wdata,
  input  logic                 dmem_gnt,
  input  logic                 dmem_rvalid,
  input  logic [XLEN-1:0]      dmem_rdata,
  output logic                 wb_valid,
  output logic [XLEN-1:0]      wb_data,
  output logic [REGADDR_W-1:0] wb_rd,
  output logic                 wb_we,
  output logic [XLEN-1:0]      fw_mem,
  output logic                 misalign
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;
  state_t state, state_nx;
  logic [XLEN-1:0] addr_q, sdata_q, wb_data_q, rshift, load_val;
  logic [3:0] op_q;
  logic [REGADDR_W-1:0] rd_q, wb_rd_q;
  logic rd_we_q, wb_valid_q, wb_we_q, mis_q;
  logic in_mem, in_mis, q_byte, q_half, q_store, q_signed;
  logic [1:0] off;
  assign in_mem = ex_mem_op >= 4'd1 && ex_mem_op <= 4'd8;
`ifdef MEMSTAGE_MISALIGN_TRAP_EN
  assign in_mis = ((ex_mem_op == 4'd2 || ex_mem_op == 4'd5 || ex_mem_op == 4'd7) && ex_result[0]) ||
                  ((ex_mem_op == 4'd3 || ex_mem_op == 4'd8) && ex_result[1:0] != 2'b00);
`else
  assign in_mis = 1'b0;
`endif
  assign q_byte   = op_q == 4'd1 || op_q == 4'd4 || op_q == 4'd6;
  assign q_half   = op_q == 4'd2 || op_q == 4'd5 || op_q == 4'd7;
  assign q_store  = op_q == 4'd6 || op_q == 4'd7 || op_q == 4'd8;
  assign q_signed = op_q == 4'd1 || op_q == 4'd2;
  // Halves and words ignore the low address bits that would make them misaligned.
  assign off = q_byte ? addr_q[1:0] : q_half ? {addr_q[1], 1'b0} : 2'b00;
  assign rshift = dmem_rdata >> {off, 3'b000};
  assign load_val = q_byte ? {{24{q_signed & rshift[7]}}, rshift[7:0]} :
                    q_half ? {{16{q_signed & rshift[15]}}, rshift[15:0]} : dmem_rdata;
  assign ex_ready   = state == IDLE;
  assign dmem_req   = state == REQ;
  assign dmem_we    = dmem_req & q_store;
  assign dmem_addr  = dmem_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign dmem_be    = !dmem_req ? 4'b0000 : q_byte ? 4'b0001 << off : q_half ? 4'b0011 << off : 4'b1111;
  assign dmem_wdata = !dmem_req ? '0 : q_byte ? {4{sdata_q[7:0]}} : q_half ? {2{sdata_q[15:0]}} : sdata_q;
  assign wb_valid = wb_valid_q;
  assign wb_data  = wb_data_q;
  assign wb_rd    = wb_rd_q;
  assign wb_we    = wb_valid_q & wb_we_q;
  assign fw_mem   = wb_data_q;
  assign misalign = mis_q;
  always_comb begin
    state_nx = state == IDLE ? ((ex_valid && in_mem && !in_mis) ? REQ : IDLE) :
               state == REQ ? (dmem_gnt ? WAIT_R : REQ) :
               state == WAIT_R ? (dmem_rvalid ? IDLE : WAIT_R) : IDLE;
  end
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      sdata_q    <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      rd_we_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_we_q    <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state      <= state_nx;
      wb_valid_q <= 1'b0;
      mis_q      <= 1'b0;
      if (state == IDLE && ex_valid) begin
        addr_q  <= ex_result;
        sdata_q <= ex_store_data;
        op_q    <= ex_mem_op;
        rd_q    <= ex_rd;
        rd_we_q <= ex_rd_we;
        if (!in_mem || in_mis) begin
          wb_valid_q <= 1'b1;
          wb_data_q  <= ex_result;
          wb_rd_q    <= ex_rd;
          wb_we_q    <= ex_rd_we & !in_mis;
          mis_q      <= in_mis;
        end
      end
      if (state == WAIT_R && dmem_rvalid) begin
        wb_valid_q <= 1'b1;
        wb_rd_q    <= rd_q;
        wb_we_q    <= rd_we_q & !q_store;
        if (!q_store) wb_data_q <= load_val;
      end
    end
  end
endmodule

// File: tb/tb_arcabuco_memory_stage.sv
// tb_arcabuco_memory_stage: randomized bench with a behavioural MEM-stage model and a bus responder.
module tb_arcabuco_memory_stage;
  logic clock = 0, rst = 0;
  logic ex_valid = 0, ex_ready, ex_rd_we = 0;
  logic [31:0] ex_result = 0, ex_store_data = 0;
  logic [3:0] ex_mem_op = 0;
  logic [4:0] ex_rd = 0;
  logic dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0] dmem_be;
  logic wb_valid, wb_we, misalign;
  logic [31:0] wb_data, fw_mem;
  logic [4:0] wb_rd;

  arcabuco_memory_stage dut (
    .clock(clock), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_result(ex_result), .ex_store_data(ex_store_data), .ex_mem_op(ex_mem_op),
    .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we),
    .fw_mem(fw_mem), .misalign(misalign)
  );

  always #5 clock = ~clock;

  typedef struct {logic [31:0] d; logic [4:0] rd; logic we; logic chk; logic mis;} exp_t;
  exp_t exp_q[$];
  int n_cmp = 0, n_bad = 0;
  logic [31:0] cur_addr, cur_wdata;
  logic [3:0] cur_be;
  logic cur_we;
  int gdly = -1, rdly = -1, gwait = 0, rcnt = 0;
  logic pend = 0, stray = 0, frc = 0;
  logic [31:0] frc_data = 0, paddr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a * 32'h9E3779B1 + 32'h01234567;
  endfunction

  function automatic logic [31:0] ldext(input logic [3:0] op, input logic [31:0] a, input logic [31:0] w);
    int b, h;
    b = int'((w >> (8 * (a % 4))) & 32'hFF);
    h = int'((w >> (16 * ((a / 2) % 2))) & 32'hFFFF);
    case (op)
      4'd1: return 32'(b > 127 ? b - 256 : b);
      4'd2: return 32'(h > 32767 ? h - 65536 : h);
      4'd4: return 32'(b);
      4'd5: return 32'(h);
      default: return w;
    endcase
  endfunction

  // Presents one instruction and records what WB and the bus must show for it.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] r, input logic w);
    exp_t e;
    int n = 0, sz;
    logic mis = 0;
    @(negedge clock);
    ex_valid = 1; ex_mem_op = op; ex_result = a; ex_store_data = d; ex_rd = r; ex_rd_we = w;
    while (!ex_ready && n < 100) begin @(negedge clock); n++; end
    if (!ex_ready) chk("ex_ready_timeout", 32'(ex_ready), 32'd1);
    e.d = a; e.rd = r; e.we = w; e.chk = 1; e.mis = 0;
    if (op >= 4'd1 && op <= 4'd8) begin
      sz = (op == 4'd1 || op == 4'd4 || op == 4'd6) ? 1 : (op == 4'd2 || op == 4'd5 || op == 4'd7) ? 2 : 4;
`ifdef MEMSTAGE_MISALIGN_TRAP_EN
      mis = (a % sz) != 0;
`endif
      if (mis) begin
        e.we = 0; e.mis = 1;
      end else begin
        cur_addr = a & ~32'd3;
        cur_we = op >= 4'd6;
        cur_be = sz == 1 ? 4'(1 << (a % 4)) : sz == 2 ? 4'(3 << (2 * ((a / 2) % 2))) : 4'hF;
        cur_wdata = sz == 1 ? (d & 32'hFF) * 32'h01010101 : sz == 2 ? (d & 32'hFFFF) * 32'h00010001 : d;
        if (cur_we) begin e.we = 0; e.chk = 0; end
        else e.d = ldext(op, a, frc ? frc_data : memf(cur_addr));
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clock);
    ex_valid = 0;
  endtask

  task automatic wait_wb();
    int n = 0;
    do begin idle(); n++; end while (!wb_valid && n < 60);
    if (!wb_valid) chk("wb_valid_timeout", 32'(wb_valid), 32'd1);
  endtask

  // Bus responder: grant after gdly request cycles, respond rdly cycles after grant (-1 = random).
  initial begin
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    forever begin
      @(negedge clock);
      dmem_gnt = 0; dmem_rvalid = 0;
      if (!rst) begin pend = 0; gwait = 0; end
      else if (stray) begin dmem_rvalid = 1; dmem_rdata = 32'hBAD0BAD0; stray = 0; end
      else if (pend) begin
        if (rcnt == 0) begin dmem_rvalid = 1; dmem_rdata = frc ? frc_data : memf(paddr); pend = 0; end
        else rcnt--;
      end else if (dmem_req) begin
        if (gwait >= (gdly < 0 ? int'($urandom_range(0, 2)) : gdly)) begin
          dmem_gnt = 1; pend = 1; paddr = dmem_addr; gwait = 0;
          rcnt = rdly < 0 ? int'($urandom_range(0, 3)) : rdly;
        end else gwait++;
      end
    end
  end

  // Per-cycle comparison of WB and bus outputs against the model.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock); #1;
      if (rst) begin
        if (wb_valid) begin
          if (exp_q.size() == 0) chk("unexpected_wb_valid", 32'(wb_valid), 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("wb_rd", 32'(wb_rd), 32'(e.rd));
            chk("wb_we", 32'(wb_we), 32'(e.we));
            chk("misalign", 32'(misalign), 32'(e.mis));
            if (e.chk) begin
              chk("wb_data", wb_data, e.d);
              chk("fw_mem", fw_mem, e.d);
            end
          end
        end else begin
          chk("wb_we_idle", 32'(wb_we), 32'd0);
          chk("misalign_idle", 32'(misalign), 32'd0);
        end
        if (dmem_gnt) chk("req_after_gnt", 32'(dmem_req), 32'd0);
        if (dmem_req) begin
          chk("dmem_addr", dmem_addr, cur_addr);
          chk("dmem_be", 32'(dmem_be), 32'(cur_be));
          chk("dmem_we", 32'(dmem_we), 32'(cur_we));
          if (cur_we) chk("dmem_wdata", dmem_wdata, cur_wdata);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    repeat (3) @(negedge clock);
    chk("rst_ex_ready", 32'(ex_ready), 32'd1);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_dmem_be", 32'(dmem_be), 32'd0);
    rst = 1;

    issue(4'd0, 32'h0000000B, 32'd0, 5'd3, 1'b1);
    issue(4'd0, 32'h00000077, 32'd0, 5'd4, 1'b1);
    chk("pt_a_valid", 32'(wb_valid), 32'd1);
    chk("pt_a_data", wb_data, 32'h0000000B);
    chk("pt_a_rd", 32'(wb_rd), 32'd3);
    chk("pt_a_we", 32'(wb_we), 32'd1);
    idle();
    chk("pt_b_valid", 32'(wb_valid), 32'd1);
    chk("pt_b_data", wb_data, 32'h00000077);

    gdly = 2; rdly = 1;
    issue(4'd6, 32'h00000103, 32'h123456A5, 5'd7, 1'b1);
    idle();
    chk("sb_req", 32'(dmem_req), 32'd1);
    chk("sb_addr", dmem_addr, 32'h00000100);
    chk("sb_be", 32'(dmem_be), 32'h8);
    chk("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
    chk("sb_ex_ready", 32'(ex_ready), 32'd0);
    wait_wb();
    chk("sb_wb_we", 32'(wb_we), 32'd0);

    gdly = 0; rdly = 0; frc = 1; frc_data = 32'h00800000;
    issue(4'd1, 32'h00000202, 32'd0, 5'd8, 1'b1);
    wait_wb();
    chk("lb_data", wb_data, 32'hFFFFFF80);
    issue(4'd4, 32'h00000202, 32'd0, 5'd8, 1'b1);
    wait_wb();
    chk("lbu_data", wb_data, 32'h00000080);
    frc_data = 32'h80010000;
    issue(4'd2, 32'h00000202, 32'd0, 5'd9, 1'b1);
    wait_wb();
    chk("lh_data", wb_data, 32'hFFFF8001);

    gdly = 3; rdly = 4; frc_data = 32'hDEADBEEF;
    issue(4'd3, 32'h00000040, 32'd0, 5'd10, 1'b1);
    wait_wb();
    chk("lw_data", wb_data, 32'hDEADBEEF);
    chk("lw_fw", fw_mem, 32'hDEADBEEF);
    frc = 0; gdly = 0; rdly = 0;

    issue(4'd3, 32'h00001002, 32'd0, 5'd11, 1'b1);
    idle();
`ifdef MEMSTAGE_MISALIGN_TRAP_EN
    chk("mis_flag", 32'(misalign), 32'd1);
    chk("mis_no_req", 32'(dmem_req), 32'd0);
    chk("mis_data", wb_data, 32'h00001002);
`else
    chk("mis_addr", dmem_addr, 32'h00001000);
    chk("mis_be", 32'(dmem_be), 32'hF);
    wait_wb();
`endif

    rdly = 1000;
    issue(4'd3, 32'h00000080, 32'd0, 5'd12, 1'b1);
    n = 0;
    do begin idle(); n++; end while (!pend && n < 50);
    idle();
    rst = 0;
    exp_q.delete();
    #1;
    chk("rst_mid_ready", 32'(ex_ready), 32'd1);
    chk("rst_mid_req", 32'(dmem_req), 32'd0);
    chk("rst_mid_wb", 32'(wb_valid), 32'd0);
    idle(); idle();
    rst = 1; rdly = -1; gdly = -1;
    stray = 1;
    repeat (4) begin
      idle();
      chk("stray_wb_valid", 32'(wb_valid), 32'd0);
      chk("stray_ready", 32'(ex_ready), 32'd1);
    end

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      issue(4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end
    n = 0;
    do begin idle(); n++; end while (exp_q.size() != 0 && n < 200);
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
